// File: rtl/arb_pkg.sv
// Shared types and constants for the riscv32b single-port memory arbiter.
package arb_pkg;

   // Default widths of the unified memory port.
   localparam int unsigned DefAw = 32;
   localparam int unsigned DefDw = 32;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIBusy = 2'd1,
      StDBusy = 2'd2
   } arb_state_e;

   // Grant encoding; also the reset value of last_gnt is GNT_I.
   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } arb_gnt_e;

   // Data wins when it is the only requester, or on a tie when instr was granted last.
   function automatic logic pick_data(input logic i_req, input logic d_req,
                                      input arb_gnt_e last_gnt);
      return d_req & (~i_req | (last_gnt == GNT_I));
   endfunction

endpackage

// File: rtl/arb_timeout.sv
// Busy-cycle watchdog for mem_arbiter: counts cycles a granted transaction has
// waited for m_ack and flags expiry once the count reaches TIMEOUT.
module arb_timeout #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] Limit = CW'(TIMEOUT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expired = (cnt_q == Limit);

   // Clear wins over enable; hold at the limit so the count never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one registered req/ack memory port between
// instruction fetch and load/store, alternating grants on ties.
// Optional feature: define ARB_TIMEOUT_EN to enable the transaction watchdog and
// the sticky bus_err flag; otherwise busy states wait forever and bus_err is 0.
module mem_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned AW      = DefAw,
   parameter int unsigned DW      = DefDw,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rstn,
   // instruction fetch requester
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_ack,
   // load/store requester
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   // unified memory port
   output logic          m_req,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   input  logic          m_ack,
   // core-facing status
   output logic          stall,
   output logic          bus_err
);

   // A zero limit would expire in the grant's first busy cycle.
   if (TIMEOUT == 0) begin : g_bad_timeout
      $error("mem_arbiter: TIMEOUT must be nonzero");
   end

   arb_state_e    state_q, state_d;
   arb_gnt_e      last_gnt_q, last_gnt_d;
   logic          m_req_q, m_req_d;
   logic          m_we_q, m_we_d;
   logic [AW-1:0] m_addr_q, m_addr_d;
   logic [DW-1:0] m_wdata_q, m_wdata_d;

   logic busy;
   logic i_sel;
   logic d_sel;
   logic tmo;
   logic done;

   assign busy  = (state_q != StIdle);
   assign i_sel = (state_q == StIBusy);
   assign d_sel = (state_q == StDBusy);

`ifdef ARB_TIMEOUT_EN
   logic expired;
   logic bus_err_q;

   arb_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (~busy),
      .en      (busy & ~m_ack),
      .expired (expired)
   );

   // A late m_ack landing on the expiry cycle is still a normal completion.
   assign tmo = busy & expired & ~m_ack;

   // Sticky error: only reset clears it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus_err_q <= 1'b0;
      end else if (tmo) begin
         bus_err_q <= 1'b1;
      end
   end

   assign bus_err = bus_err_q;
`else
   assign tmo     = 1'b0;
   assign bus_err = 1'b0;
`endif

   assign done = busy & (m_ack | tmo);

   // Next-state and registered memory-port values.
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      m_req_d    = m_req_q;
      m_we_d     = m_we_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      unique case (state_q)
         StIdle: begin
            if (pick_data(i_req, d_req, last_gnt_q)) begin
               state_d    = StDBusy;
               last_gnt_d = GNT_D;
               m_req_d    = 1'b1;
               m_we_d     = d_we;
               m_addr_d   = d_addr;
               m_wdata_d  = d_wdata;
            end else if (i_req) begin
               state_d    = StIBusy;
               last_gnt_d = GNT_I;
               m_req_d    = 1'b1;
               m_we_d     = 1'b0;
               m_addr_d   = i_addr;
            end
         end
         StIBusy, StDBusy: begin
            // m_* stay frozen for the whole transaction; only m_req drops at the end.
            if (done) begin
               state_d = StIdle;
               m_req_d = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            m_req_d = 1'b0;
         end
      endcase
   end

   // State and memory-port registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         last_gnt_q <= GNT_I;
         m_req_q    <= 1'b0;
         m_we_q     <= 1'b0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         m_req_q    <= m_req_d;
         m_we_q     <= m_we_d;
         m_addr_q   <= m_addr_d;
         m_wdata_q  <= m_wdata_d;
      end
   end

   // Requester acks and read data, combinational from the memory response.
   always_comb begin
      i_ack   = i_sel & (m_ack | tmo);
      d_ack   = d_sel & (m_ack | tmo);
      i_rdata = (i_sel & m_ack) ? m_rdata : '0;
      d_rdata = (d_sel & m_ack) ? m_rdata : '0;
      stall   = (i_req & ~i_ack) | (d_req & ~d_ack);
   end

   assign m_req   = m_req_q;
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Build with ARB_TIMEOUT_EN to
// also exercise the watchdog (TIMEOUT is 4 here).
module tb_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rstn;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_ack;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;
   logic          m_req;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          m_ack;
   logic          stall;
   logic          bus_err;

   int n_chk = 0;
   int n_bad = 0;

   mem_arbiter #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (4)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_rdata (i_rdata),
      .i_ack   (i_ack),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_rdata (d_rdata),
      .d_ack   (d_ack),
      .m_req   (m_req),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata),
      .m_ack   (m_ack),
      .stall   (stall),
      .bus_err (bus_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs driven and outputs sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_req   = 1'b0;
      i_addr  = '0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      m_rdata = '0;
      m_ack   = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
   endtask

   // One arbitration round with both requesters pending; memory acks one cycle after m_req.
   task automatic serve_round(input string tag, input logic [31:0] exp_addr,
                              input logic is_data, input logic [31:0] rd);
      tick();
      check_eq({tag, " m_req"}, 32'(m_req), 32'd1);
      check_eq({tag, " m_addr"}, m_addr, exp_addr);
      tick();
      m_ack   = 1'b1;
      m_rdata = rd;
      #1;
      check_eq({tag, " i_ack"}, 32'(i_ack), 32'(!is_data));
      check_eq({tag, " d_ack"}, 32'(d_ack), 32'(is_data));
      check_eq({tag, " rdata"}, is_data ? d_rdata : i_rdata, rd);
      check_eq({tag, " stall"}, 32'(stall), 32'd1);
      tick();
      m_ack = 1'b0;
      check_eq({tag, " m_req drop"}, 32'(m_req), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      // Reset state
      do_reset();
      check_eq("rst m_req", 32'(m_req), 32'd0);
      check_eq("rst m_we", 32'(m_we), 32'd0);
      check_eq("rst m_addr", m_addr, 32'd0);
      check_eq("rst m_wdata", m_wdata, 32'd0);
      check_eq("rst acks", {30'd0, i_ack, d_ack}, 32'd0);
      check_eq("rst stall", 32'(stall), 32'd0);
      check_eq("rst bus_err", 32'(bus_err), 32'd0);

      // Single fetch, memory acks two cycles after m_req
      i_req  = 1'b1;
      i_addr = 32'h100;
      #1;
      check_eq("fetch stall pre", 32'(stall), 32'd1);
      tick();
      check_eq("fetch m_req", 32'(m_req), 32'd1);
      check_eq("fetch m_addr", m_addr, 32'h100);
      check_eq("fetch m_we", 32'(m_we), 32'd0);
      check_eq("fetch no ack", 32'(i_ack), 32'd0);
      tick();
      check_eq("fetch held", 32'(m_req), 32'd1);
      check_eq("fetch i_rdata idle", i_rdata, 32'd0);
      tick();
      m_ack   = 1'b1;
      m_rdata = 32'h0000_0013;
      #1;
      check_eq("fetch i_ack", 32'(i_ack), 32'd1);
      check_eq("fetch i_rdata", i_rdata, 32'h13);
      check_eq("fetch d_ack", 32'(d_ack), 32'd0);
      check_eq("fetch stall ack", 32'(stall), 32'd0);
      i_req = 1'b0;
      tick();
      m_ack = 1'b0;
      #1;
      check_eq("fetch m_req drop", 32'(m_req), 32'd0);
      check_eq("fetch ack pulse", 32'(i_ack), 32'd0);

      // Store
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h2000;
      d_wdata = 32'hDEAD_BEEF;
      tick();
      check_eq("store m_req", 32'(m_req), 32'd1);
      check_eq("store m_we", 32'(m_we), 32'd1);
      check_eq("store m_addr", m_addr, 32'h2000);
      check_eq("store m_wdata", m_wdata, 32'hDEAD_BEEF);
      tick();
      check_eq("store wdata held", m_wdata, 32'hDEAD_BEEF);
      check_eq("store d_ack wait", 32'(d_ack), 32'd0);
      check_eq("store stall wait", 32'(stall), 32'd1);
      tick();
      m_ack = 1'b1;
      #1;
      check_eq("store d_ack", 32'(d_ack), 32'd1);
      check_eq("store i_ack", 32'(i_ack), 32'd0);
      d_req = 1'b0;
      d_we  = 1'b0;
      tick();
      m_ack = 1'b0;
      check_eq("store m_req drop", 32'(m_req), 32'd0);

      // Simultaneous requests from reset: grants alternate D, I, D, I
      do_reset();
      i_req  = 1'b1;
      i_addr = 32'h40;
      d_req  = 1'b1;
      d_addr = 32'h80;
      serve_round("tie0", 32'h80, 1'b1, 32'hD000_0000);
      serve_round("tie1", 32'h40, 1'b0, 32'h1000_0001);
      serve_round("tie2", 32'h80, 1'b1, 32'hD000_0002);
      serve_round("tie3", 32'h40, 1'b0, 32'h1000_0003);
      i_req = 1'b0;
      d_req = 1'b0;
      tick();

      // Zero-wait memory: ack in the cycle m_req rises, next grant two cycles later
      i_req  = 1'b1;
      i_addr = 32'h200;
      tick();
      m_ack   = 1'b1;
      m_rdata = 32'hAAAA_0001;
      #1;
      check_eq("zw ack", 32'(i_ack), 32'd1);
      check_eq("zw rdata", i_rdata, 32'hAAAA_0001);
      i_addr = 32'h204;
      tick();
      m_ack = 1'b0;
      check_eq("zw idle gap", 32'(m_req), 32'd0);
      tick();
      check_eq("zw regrant", 32'(m_req), 32'd1);
      check_eq("zw regrant addr", m_addr, 32'h204);
      m_ack = 1'b1;
      #1;
      check_eq("zw ack2", 32'(i_ack), 32'd1);
      i_req = 1'b0;
      tick();
      m_ack = 1'b0;
      check_eq("zw m_req drop", 32'(m_req), 32'd0);

      // Stray m_ack while idle is ignored
      m_ack = 1'b1;
      #1;
      check_eq("idle ack ignored", {30'd0, i_ack, d_ack}, 32'd0);
      tick();
      m_ack = 1'b0;
      check_eq("idle no grant", 32'(m_req), 32'd0);

`ifdef ARB_TIMEOUT_EN
      // Timeout: data load never acked
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 32'h300;
      m_rdata = 32'hFFFF_FFFF;
      tick();
      check_eq("tmo m_req", 32'(m_req), 32'd1);
      check_eq("tmo busy1", 32'(d_ack), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("tmo wait", 32'(d_ack), 32'd0);
      end
      tick();
      check_eq("tmo d_ack", 32'(d_ack), 32'd1);
      check_eq("tmo d_rdata", d_rdata, 32'd0);
      check_eq("tmo err pre", 32'(bus_err), 32'd0);
      d_req = 1'b0;
      tick();
      check_eq("tmo bus_err", 32'(bus_err), 32'd1);
      check_eq("tmo m_req drop", 32'(m_req), 32'd0);
      i_req  = 1'b1;
      i_addr = 32'h44;
      tick();
      check_eq("tmo fetch m_addr", m_addr, 32'h44);
      m_ack   = 1'b1;
      m_rdata = 32'h77;
      #1;
      check_eq("tmo fetch i_ack", 32'(i_ack), 32'd1);
      check_eq("tmo fetch rdata", i_rdata, 32'h77);
      i_req = 1'b0;
      tick();
      m_ack = 1'b0;
      check_eq("tmo err sticky", 32'(bus_err), 32'd1);
`else
      check_eq("no tmo bus_err", 32'(bus_err), 32'd0);
`endif

      // Reset asserted mid-transaction in DBUSY
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h500;
      d_wdata = 32'h1234;
      tick();
      check_eq("mid m_req", 32'(m_req), 32'd1);
      #2;
      m_ack = 1'b1;
      rstn  = 1'b0;
      #1;
      check_eq("mid rst m_req", 32'(m_req), 32'd0);
      check_eq("mid rst d_ack", 32'(d_ack), 32'd0);
      check_eq("mid rst m_addr", m_addr, 32'd0);
      check_eq("mid rst m_wdata", m_wdata, 32'd0);
      check_eq("mid rst m_we", 32'(m_we), 32'd0);
      check_eq("mid rst bus_err", 32'(bus_err), 32'd0);
      d_req = 1'b0;
      d_we  = 1'b0;
      m_ack = 1'b0;
      #2;
      rstn   = 1'b1;
      i_req  = 1'b1;
      i_addr = 32'h600;
      tick();
      check_eq("post rst m_req", 32'(m_req), 32'd1);
      check_eq("post rst m_addr", m_addr, 32'h600);
      check_eq("post rst m_we", 32'(m_we), 32'd0);
      m_ack   = 1'b1;
      m_rdata = 32'h5A;
      #1;
      check_eq("post rst i_ack", 32'(i_ack), 32'd1);
      i_req = 1'b0;
      tick();
      m_ack = 1'b0;
      check_eq("post rst drop", 32'(m_req), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
